// File: rtl/dtc_fe_rx.sv
// dtc_fe_rx: e-port front-end receiver.
// Hunts for a packet header byte, verifies a run of good headers, then holds
// lock. While locked it assembles 8-word (256-bit) packets and commits the
// ones with a good header into a two-slot ping-pong output buffer.
//
// Ports:
//   CLK40        - single clock, rising edge
//   RESET_N      - asynchronous active-low reset
//   EPORT_IN     - one 32-bit e-port word, first nibble in [31:28]
//   EPORT_VALID  - EPORT_IN qualifier
//   PKT_DATA     - oldest buffered packet, word 0 in [255:224]
//   PKT_VALID    - PKT_DATA holds an unconsumed packet
//   PKT_READY    - consumer accept strobe
//   LOCKED       - FSM is in LOCKED
//   SYNC_ERR_CNT - saturating count of header misses while locked
//   OVERFLOW     - one-cycle pulse when a complete packet is dropped
module dtc_fe_rx #(
    parameter logic [7:0]  SYNC_WORD     = 8'hA5,
    parameter int unsigned LOCK_THRESH   = 4,
    parameter int unsigned UNLOCK_THRESH = 2
) (
    input  logic         CLK40,
    input  logic         RESET_N,
    input  logic [31:0]  EPORT_IN,
    input  logic         EPORT_VALID,
    output logic [255:0] PKT_DATA,
    output logic         PKT_VALID,
    input  logic         PKT_READY,
    output logic         LOCKED,
    output logic [7:0]   SYNC_ERR_CNT,
    output logic         OVERFLOW
);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

    state_t         r_state;
    logic [2:0]     r_idx;
    logic [31:0]    r_good;
    logic [31:0]    r_miss;
    logic           r_pkt_ok;   // current packet's header was good and seen while locked
    logic           r_locked;
    logic [7:0]     r_err_cnt;
    logic [255:0]   r_asm;

    logic [255:0]   r_slot [2];
    logic [1:0]     r_full;
    logic           r_wr;
    logic           r_rd;
    logic           r_ovf;

    logic           w_hdr_ok;
    logic [255:0]   w_asm_next;
    logic           w_commit;
    logic           w_xfer;
    logic           w_slot_free;

    assign w_hdr_ok = (EPORT_IN[31:24] == SYNC_WORD);

    // Word at index i lands in slice (7-i); for a 3-bit index that is ~i.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{~r_idx, 5'd0} +: 32] = EPORT_IN;
    end

    // r_pkt_ok is only ever set in LOCKED, and LOCKED is only left at index 0,
    // so a set flag at index 7 implies the packet is eligible.
    assign w_commit    = EPORT_VALID && (r_state != ST_HUNT) && (r_idx == 3'd7) && r_pkt_ok;
    assign w_xfer      = PKT_VALID && PKT_READY;
    // Both slots full implies wr == rd, so a same-cycle transfer frees the write slot.
    assign w_slot_free = !r_full[r_wr] || (w_xfer && (r_wr == r_rd));

    always_ff @(posedge CLK40 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_HUNT;
            r_idx     <= '0;
            r_good    <= '0;
            r_miss    <= '0;
            r_pkt_ok  <= 1'b0;
            r_locked  <= 1'b0;
            r_err_cnt <= '0;
            r_asm     <= '0;
        end else if (EPORT_VALID) begin
            if (r_state != ST_HUNT) begin
                r_asm <= w_asm_next;
            end
            case (r_state)
                ST_HUNT: begin
                    if (w_hdr_ok) begin
                        r_state  <= ST_VERIFY;
                        r_idx    <= 3'd1;
                        r_good   <= 32'd1;
                        r_pkt_ok <= 1'b0;
                    end
                end
                ST_VERIFY: begin
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'd0) begin
                        r_pkt_ok <= 1'b0;
                        if (w_hdr_ok) begin
                            r_good <= r_good + 32'd1;
                            if (r_good + 32'd1 >= LOCK_THRESH) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                                r_miss   <= '0;
                            end
                        end else begin
                            r_state <= ST_HUNT;
                            r_good  <= '0;
                            r_idx   <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'd0) begin
                        if (w_hdr_ok) begin
                            r_miss   <= '0;
                            r_pkt_ok <= 1'b1;
                        end else begin
                            r_pkt_ok <= 1'b0;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                            if (r_miss + 32'd1 >= UNLOCK_THRESH) begin
                                r_state  <= ST_HUNT;
                                r_locked <= 1'b0;
                                r_miss   <= '0;
                                r_good   <= '0;
                                r_idx    <= '0;
                            end else begin
                                r_miss <= r_miss + 32'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= ST_HUNT;
                    r_locked <= 1'b0;
                    r_idx    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK40 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_full    <= '0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_xfer) begin
                r_full[r_rd] <= 1'b0;
                r_rd         <= ~r_rd;
            end
            // Placed after the free so a reuse of the same slot keeps it full.
            if (w_commit) begin
                if (w_slot_free) begin
                    r_slot[r_wr] <= w_asm_next;
                    r_full[r_wr] <= 1'b1;
                    r_wr         <= ~r_wr;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign PKT_DATA     = r_slot[r_rd];
    assign PKT_VALID    = r_full[r_rd];
    assign LOCKED       = r_locked;
    assign SYNC_ERR_CNT = r_err_cnt;
    assign OVERFLOW     = r_ovf;

endmodule

// File: tb/tb_dtc_fe_rx.sv
module tb_dtc_fe_rx;

    logic         CLK40 = 1'b0;
    logic         RESET_N;
    logic [31:0]  EPORT_IN;
    logic         EPORT_VALID;
    logic [255:0] PKT_DATA;
    logic         PKT_VALID;
    logic         PKT_READY;
    logic         LOCKED;
    logic [7:0]   SYNC_ERR_CNT;
    logic         OVERFLOW;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int ovf_cnt = 0;
    int xfers_exp = 0;
    int ovf_before;
    logic [255:0] sb_q [$];

    dtc_fe_rx #(.SYNC_WORD(8'hA5), .LOCK_THRESH(4), .UNLOCK_THRESH(2)) dut (
        .CLK40        (CLK40),
        .RESET_N      (RESET_N),
        .EPORT_IN     (EPORT_IN),
        .EPORT_VALID  (EPORT_VALID),
        .PKT_DATA     (PKT_DATA),
        .PKT_VALID    (PKT_VALID),
        .PKT_READY    (PKT_READY),
        .LOCKED       (LOCKED),
        .SYNC_ERR_CNT (SYNC_ERR_CNT),
        .OVERFLOW     (OVERFLOW)
    );

    always #5 CLK40 = ~CLK40;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    // Output monitor: inputs change just after posedge, so the negedge view
    // is what the next posedge will act on.
    always @(negedge CLK40) begin
        if (RESET_N) begin
            if (OVERFLOW) ovf_cnt++;
            if (PKT_VALID) begin
                chk("sb_nonempty", 256'(sb_q.size() > 0), 256'd1);
                if (sb_q.size() > 0) begin
                    chk("pkt_data", PKT_DATA, sb_q[0]);
                    if (PKT_READY) begin
                        void'(sb_q.pop_front());
                        xfers++;
                    end
                end
            end
        end
    end

    // Sends nw words of a packet. Payload top bytes never equal the sync word
    // so a stream in HUNT only re-acquires on real headers.
    task automatic send_pkt(input logic [7:0] hdr, input int nw, input bit push,
                            input bit gaps, input bit rdy_last);
        logic [255:0] pkt;
        logic [31:0]  w;
        pkt = '0;
        for (int i = 0; i < nw; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    EPORT_VALID = 1'b0;
                    EPORT_IN    = $urandom;
                    tick();
                end
            end
            w = $urandom;
            if (i == 0) w[31:24] = hdr;
            else if (w[31:24] == 8'hA5) w[31:24] = 8'h5A;
            pkt[(7 - i) * 32 +: 32] = w;
            if (i == 7) begin
                if (push) sb_q.push_back(pkt);
                if (rdy_last) PKT_READY = 1'b1;
            end
            EPORT_IN    = w;
            EPORT_VALID = 1'b1;
            tick();
        end
        EPORT_VALID = 1'b0;
    endtask

    initial begin
        RESET_N     = 1'b0;
        EPORT_IN    = '0;
        EPORT_VALID = 1'b0;
        PKT_READY   = 1'b1;
        #3;
        chk("rst_valid",  PKT_VALID, 0);
        chk("rst_data",   PKT_DATA, 0);
        chk("rst_locked", LOCKED, 0);
        chk("rst_err",    SYNC_ERR_CNT, 0);
        chk("rst_ovf",    OVERFLOW, 0);
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();

        // Lock: 4 headers to lock, packet 5 is the first delivered
        for (int p = 0; p < 3; p++) send_pkt(8'hA5, 8, 0, 0, 0);
        chk("lock_pre", LOCKED, 0);
        send_pkt(8'hA5, 8, 0, 0, 0);
        chk("lock_post", LOCKED, 1);
        chk("pkt4_dropped", PKT_VALID, 0);
        send_pkt(8'hA5, 8, 1, 0, 0);
        chk("latency", PKT_VALID, 1);
        xfers_exp += 1;
        repeat (4) tick();
        chk("lock_xfers", xfers, xfers_exp);
        chk("lock_valid_low", PKT_VALID, 0);

        // Unlock: two bad headers
        send_pkt(8'h00, 8, 0, 0, 0);
        chk("miss1_locked", LOCKED, 1);
        chk("miss1_err", SYNC_ERR_CNT, 1);
        send_pkt(8'h00, 8, 0, 0, 0);
        chk("unlock", LOCKED, 0);
        chk("unlock_err", SYNC_ERR_CNT, 2);
        repeat (4) tick();
        chk("unlock_xfers", xfers, xfers_exp);

        // Relock
        for (int p = 0; p < 4; p++) send_pkt(8'hA5, 8, 0, 0, 0);
        chk("relock", LOCKED, 1);

        // Backpressure: third packet overflows
        PKT_READY  = 1'b0;
        ovf_before = ovf_cnt;
        send_pkt(8'hA5, 8, 1, 0, 0);
        send_pkt(8'hA5, 8, 1, 0, 0);
        send_pkt(8'hA5, 8, 0, 0, 0);
        repeat (3) tick();
        chk("bp_valid", PKT_VALID, 1);
        chk("bp_ovf", ovf_cnt - ovf_before, 1);
        PKT_READY = 1'b1;
        xfers_exp += 2;
        repeat (5) tick();
        chk("bp_xfers", xfers, xfers_exp);

        // Commit and transfer in the same cycle with both slots full
        PKT_READY  = 1'b0;
        ovf_before = ovf_cnt;
        send_pkt(8'hA5, 8, 1, 0, 0);
        send_pkt(8'hA5, 8, 1, 0, 0);
        send_pkt(8'hA5, 8, 1, 0, 1);
        xfers_exp += 3;
        repeat (6) tick();
        chk("simul_ovf", ovf_cnt - ovf_before, 0);
        chk("simul_xfers", xfers, xfers_exp);

        // Gaps inside packets
        for (int p = 0; p < 3; p++) send_pkt(8'hA5, 8, 1, 1, 0);
        xfers_exp += 3;
        repeat (4) tick();
        chk("gap_xfers", xfers, xfers_exp);

        // Reset mid-packet with a buffered packet pending
        PKT_READY = 1'b0;
        send_pkt(8'hA5, 8, 1, 0, 0);
        send_pkt(8'hA5, 4, 0, 0, 0);
        chk("prerst_valid", PKT_VALID, 1);
        chk("prerst_err", SYNC_ERR_CNT, 2);
        #2;
        RESET_N = 1'b0;
        #1;
        sb_q.delete();
        chk("arst_valid",  PKT_VALID, 0);
        chk("arst_data",   PKT_DATA, 0);
        chk("arst_locked", LOCKED, 0);
        chk("arst_err",    SYNC_ERR_CNT, 0);
        chk("arst_ovf",    OVERFLOW, 0);
        repeat (2) tick();
        RESET_N   = 1'b1;
        PKT_READY = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) send_pkt(8'hA5, 8, 0, 0, 0);
        chk("rst_relock_pre", LOCKED, 0);
        send_pkt(8'hA5, 8, 0, 0, 0);
        chk("rst_relock", LOCKED, 1);
        chk("rst_relock_nopkt", PKT_VALID, 0);
        send_pkt(8'hA5, 8, 1, 0, 0);
        chk("rst_latency", PKT_VALID, 1);
        xfers_exp += 1;
        repeat (4) tick();
        chk("final_xfers", xfers, xfers_exp);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
